// File: rtl/cache_axi_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : cache_axi_wr_sched
// Purpose  : AXI write-channel scheduler for the cache complex. Arbitrates the
//            AW requests of N_SRC write-capable sources (0 = I$, 1 = bypass,
//            2 = D$) round-robin, records the granted order in a small FIFO so
//            W beats are forwarded strictly in AW order, limits per-source
//            outstanding writes to MAX_OUT, and routes B responses back by
//            the ID-decoded source index.
// Ports    : clk_i/rst_i            clock, synchronous active-high reset
//            src_aw_* / mst_aw_*    AW handshakes, aw_sel_o steers AW data mux
//            src_w_*  / mst_w_*     W handshakes, w_sel_o steers W data mux
//            mst_b_* / b_src_i      B response from memory side
//            src_b_*                per-source B handshakes
//            busy_o                 writes in flight
//            err_o                  sticky flag: B arrived for no known write
// Revision : 1.0 - initial release
// ============================================================================
module cache_axi_wr_sched #(
    parameter int N_SRC   = 3,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_SRC-1:0] src_aw_valid_i,
    output logic [N_SRC-1:0] src_aw_ready_o,
    output logic             mst_aw_valid_o,
    input  logic             mst_aw_ready_i,
    output logic [1:0]       aw_sel_o,
    input  logic [N_SRC-1:0] src_w_valid_i,
    input  logic [N_SRC-1:0] src_w_last_i,
    output logic [N_SRC-1:0] src_w_ready_o,
    output logic             mst_w_valid_o,
    output logic             mst_w_last_o,
    input  logic             mst_w_ready_i,
    output logic [1:0]       w_sel_o,
    input  logic             mst_b_valid_i,
    input  logic [1:0]       b_src_i,
    output logic             mst_b_ready_o,
    output logic [N_SRC-1:0] src_b_valid_o,
    input  logic [N_SRC-1:0] src_b_ready_i,
    output logic             busy_o,
    output logic             err_o
);

    localparam int                c_CNT_W   = $clog2(MAX_OUT + 1);
    localparam int                c_PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_CNT_W-1:0] c_MAX_OUT = c_CNT_W'(MAX_OUT);
    localparam logic [c_PTR_W:0]   c_DEPTH   = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST    = c_PTR_W'(DEPTH - 1);

    // Write-order FIFO: holds the source index of every accepted AW whose
    // W burst has not yet completed.
    logic [1:0]         r_fifo_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_fifo_cnt;

    logic [c_CNT_W-1:0] r_cnt [N_SRC];
    logic [1:0]         r_rr_ptr;
    logic               r_lock;
    logic [1:0]         r_lock_sel;
    logic               r_err;

    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic [1:0]         w_head;
    logic [N_SRC-1:0]   w_eligible;
    logic               w_arb_valid;
    logic [1:0]         w_arb_sel;
    logic               w_grant_valid;
    logic [1:0]         w_grant;
    logic               w_aw_hs;
    logic               w_w_pop;
    logic               w_b_bad;
    logic               w_b_hs;
    logic               w_b_err;
    logic               w_cnt_busy;
    int                 v_best;
    int                 v_dist;

    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_fifo_full  = (r_fifo_cnt == c_DEPTH);
    assign w_head       = r_fifo_mem[r_rd_ptr];

    // A full FIFO blocks every source, even if a pop happens this cycle:
    // eligibility only looks at registered occupancy.
    for (genvar g = 0; g < N_SRC; g++) begin : g_elig
        assign w_eligible[g] = src_aw_valid_i[g] && (r_cnt[g] < c_MAX_OUT) && !w_fifo_full;
    end

    // Round-robin: pick the eligible source with the smallest forward
    // distance from the rotating pointer.
    always_comb begin
        w_arb_valid = 1'b0;
        w_arb_sel   = 2'd0;
        v_best      = N_SRC;
        v_dist      = 0;
        for (int i = 0; i < N_SRC; i++) begin
            v_dist = (i + N_SRC - int'(r_rr_ptr)) % N_SRC;
            if (w_eligible[i] && (v_dist < v_best)) begin
                v_best      = v_dist;
                w_arb_valid = 1'b1;
                w_arb_sel   = 2'(i);
            end
        end
    end

    // Once AW is presented without ready, the grant is frozen so the AW
    // payload stays stable until the handshake.
    assign w_grant_valid = r_lock || w_arb_valid;
    assign w_grant       = r_lock ? r_lock_sel : w_arb_sel;

    // A B is unexpected if its source is out of range or has nothing open.
    always_comb begin
        w_b_bad = 1'b1;
        for (int i = 0; i < N_SRC; i++) begin
            if (b_src_i == 2'(i)) begin
                w_b_bad = (r_cnt[i] == '0);
            end
        end
    end

    always_comb begin
        w_cnt_busy = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_cnt[i] != '0) begin
                w_cnt_busy = 1'b1;
            end
        end
    end

    // Output muxing; everything is forced quiet while reset is asserted.
    always_comb begin
        src_aw_ready_o = '0;
        mst_aw_valid_o = 1'b0;
        aw_sel_o       = 2'd0;
        src_w_ready_o  = '0;
        mst_w_valid_o  = 1'b0;
        mst_w_last_o   = 1'b0;
        w_sel_o        = 2'd0;
        src_b_valid_o  = '0;
        mst_b_ready_o  = 1'b0;
        if (!rst_i) begin
            if (w_grant_valid) begin
                mst_aw_valid_o = 1'b1;
                aw_sel_o       = w_grant;
            end
            if (!w_fifo_empty) begin
                w_sel_o = w_head;
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (w_grant_valid && (w_grant == 2'(i))) begin
                    src_aw_ready_o[i] = mst_aw_ready_i;
                end
                if (!w_fifo_empty && (w_head == 2'(i))) begin
                    mst_w_valid_o    = src_w_valid_i[i];
                    mst_w_last_o     = src_w_last_i[i];
                    src_w_ready_o[i] = mst_w_ready_i;
                end
            end
            if (mst_b_valid_i) begin
                if (w_b_bad) begin
                    mst_b_ready_o = 1'b1;
                end else begin
                    for (int i = 0; i < N_SRC; i++) begin
                        if (b_src_i == 2'(i)) begin
                            src_b_valid_o[i] = 1'b1;
                            mst_b_ready_o    = src_b_ready_i[i];
                        end
                    end
                end
            end
        end
    end

    assign w_aw_hs = mst_aw_valid_o && mst_aw_ready_i;
    assign w_w_pop = mst_w_valid_o && mst_w_ready_i && mst_w_last_o;
    assign w_b_hs  = mst_b_valid_i && mst_b_ready_o && !w_b_bad;
    assign w_b_err = !rst_i && mst_b_valid_i && w_b_bad;

    assign busy_o = !rst_i && (!w_fifo_empty || w_cnt_busy);
    assign err_o  = !rst_i && r_err;

    // FIFO storage needs no reset; validity is tracked by the counters.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_aw_hs) begin
            r_fifo_mem[r_wr_ptr] <= w_grant;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_rr_ptr   <= 2'd0;
            r_lock     <= 1'b0;
            r_lock_sel <= 2'd0;
            r_err      <= 1'b0;
            for (int i = 0; i < N_SRC; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            if (w_aw_hs) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
                r_rr_ptr <= (w_grant == 2'(N_SRC - 1)) ? 2'd0 : w_grant + 2'd1;
                r_lock   <= 1'b0;
            end else if (mst_aw_valid_o) begin
                r_lock     <= 1'b1;
                r_lock_sel <= w_grant;
            end
            if (w_w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_aw_hs && !w_w_pop) begin
                r_fifo_cnt <= r_fifo_cnt + 1'b1;
            end else if (!w_aw_hs && w_w_pop) begin
                r_fifo_cnt <= r_fifo_cnt - 1'b1;
            end
            if (w_b_err) begin
                r_err <= 1'b1;
            end
            // Same-cycle AW and B for one source cancel out.
            for (int i = 0; i < N_SRC; i++) begin
                if ((w_aw_hs && (w_grant == 2'(i))) && !(w_b_hs && (b_src_i == 2'(i)))) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (!(w_aw_hs && (w_grant == 2'(i))) && (w_b_hs && (b_src_i == 2'(i)))) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_axi_wr_sched
// Purpose  : Self-checking bench for cache_axi_wr_sched. A queue-based model
//            of the write ordering, outstanding counts and round-robin rules
//            predicts every output each cycle; directed scenarios add
//            explicit checks, followed by a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_axi_wr_sched;

    localparam int N  = 3;
    localparam int D  = 4;
    localparam int MO = 4;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [N-1:0] src_aw_valid_i, src_aw_ready_o;
    logic         mst_aw_valid_o, mst_aw_ready_i;
    logic [1:0]   aw_sel_o;
    logic [N-1:0] src_w_valid_i, src_w_last_i, src_w_ready_o;
    logic         mst_w_valid_o, mst_w_last_o, mst_w_ready_i;
    logic [1:0]   w_sel_o;
    logic         mst_b_valid_i, mst_b_ready_o;
    logic [1:0]   b_src_i;
    logic [N-1:0] src_b_valid_o, src_b_ready_i;
    logic         busy_o, err_o;

    always #5 clk_i = ~clk_i;

    cache_axi_wr_sched #(.N_SRC(N), .DEPTH(D), .MAX_OUT(MO)) u_dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .src_aw_valid_i (src_aw_valid_i),
        .src_aw_ready_o (src_aw_ready_o),
        .mst_aw_valid_o (mst_aw_valid_o),
        .mst_aw_ready_i (mst_aw_ready_i),
        .aw_sel_o       (aw_sel_o),
        .src_w_valid_i  (src_w_valid_i),
        .src_w_last_i   (src_w_last_i),
        .src_w_ready_o  (src_w_ready_o),
        .mst_w_valid_o  (mst_w_valid_o),
        .mst_w_last_o   (mst_w_last_o),
        .mst_w_ready_i  (mst_w_ready_i),
        .w_sel_o        (w_sel_o),
        .mst_b_valid_i  (mst_b_valid_i),
        .b_src_i        (b_src_i),
        .mst_b_ready_o  (mst_b_ready_o),
        .src_b_valid_o  (src_b_valid_o),
        .src_b_ready_i  (src_b_ready_i),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_q[$];
    int m_cnt[N];
    int m_rr;
    int m_lock;
    bit m_err;

    // Snapshot of the DUT taken at the last check point
    logic         s_aw_valid, s_w_valid, s_w_hs, s_b_ready, s_busy, s_err;
    logic [1:0]   s_aw_sel, s_w_sel;
    logic [N-1:0] s_aw_rdy, s_w_rdy, s_b_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        src_aw_valid_i = '0; mst_aw_ready_i = 1'b0;
        src_w_valid_i  = '0; src_w_last_i   = '0; mst_w_ready_i = 1'b0;
        mst_b_valid_i  = 1'b0; b_src_i = 2'd0; src_b_ready_i = '0;
    endtask

    // One clock: predict and compare at the falling edge, advance the model,
    // then return just after the rising edge so the caller can drive inputs.
    task automatic cycle();
        int grant, head, s;
        bit bad, busy;
        @(negedge clk_i);
        s_aw_valid = mst_aw_valid_o; s_aw_sel = aw_sel_o; s_aw_rdy = src_aw_ready_o;
        s_w_valid  = mst_w_valid_o;  s_w_sel  = w_sel_o;  s_w_rdy  = src_w_ready_o;
        s_w_hs     = mst_w_valid_o && mst_w_ready_i;
        s_b_ready  = mst_b_ready_o;  s_b_valid = src_b_valid_o;
        s_busy     = busy_o;         s_err     = err_o;
        if (rst_i) begin
            chk("rst_aw_valid", mst_aw_valid_o, 0);
            chk("rst_aw_sel",   aw_sel_o, 0);
            chk("rst_aw_ready", src_aw_ready_o, 0);
            chk("rst_w_valid",  mst_w_valid_o, 0);
            chk("rst_w_sel",    w_sel_o, 0);
            chk("rst_w_ready",  src_w_ready_o, 0);
            chk("rst_b_valid",  src_b_valid_o, 0);
            chk("rst_busy",     busy_o, 0);
            chk("rst_err",      err_o, 0);
            m_q.delete();
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_rr = 0; m_lock = -1; m_err = 0;
        end else begin
            grant = -1;
            if (m_lock >= 0) grant = m_lock;
            else if (m_q.size() < D) begin
                for (int k = 0; k < N; k++) begin
                    s = (m_rr + k) % N;
                    if (grant < 0 && src_aw_valid_i[s] && m_cnt[s] < MO) grant = s;
                end
            end
            head = (m_q.size() > 0) ? m_q[0] : -1;
            bad  = (int'(b_src_i) >= N) ? 1'b1 : (m_cnt[b_src_i] == 0);
            busy = (m_q.size() > 0);
            for (int i = 0; i < N; i++) if (m_cnt[i] > 0) busy = 1'b1;

            chk("aw_valid", mst_aw_valid_o, (grant >= 0));
            chk("aw_sel",   aw_sel_o, (grant >= 0) ? grant : 0);
            chk("aw_ready", src_aw_ready_o, (grant >= 0 && mst_aw_ready_i) ? (1 << grant) : 0);
            chk("w_sel",    w_sel_o, (head >= 0) ? head : 0);
            chk("w_valid",  mst_w_valid_o, (head >= 0) ? src_w_valid_i[head] : 0);
            chk("w_last",   mst_w_last_o,  (head >= 0) ? src_w_last_i[head] : 0);
            chk("w_ready",  src_w_ready_o, (head >= 0 && mst_w_ready_i) ? (1 << head) : 0);
            chk("b_ready",  mst_b_ready_o, mst_b_valid_i && (bad || src_b_ready_i[b_src_i]));
            chk("b_valid",  src_b_valid_o, (mst_b_valid_i && !bad) ? (1 << b_src_i) : 0);
            chk("busy",     busy_o, busy);
            chk("err",      err_o, m_err);

            if (head >= 0 && src_w_valid_i[head] && src_w_last_i[head] && mst_w_ready_i)
                void'(m_q.pop_front());
            if (grant >= 0 && mst_aw_ready_i) begin
                m_q.push_back(grant);
                m_cnt[grant]++;
                m_rr   = (grant + 1) % N;
                m_lock = -1;
            end else if (grant >= 0) begin
                m_lock = grant;
            end
            if (mst_b_valid_i) begin
                if (bad) m_err = 1'b1;
                else if (src_b_ready_i[b_src_i]) m_cnt[b_src_i]--;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
    endtask

    initial begin
        int beats, n;
        m_rr = 0; m_lock = -1; m_err = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        idle();
        do_reset();
        cycle();
        chk("reset_idle_busy", s_busy, 0);

        // Round-robin order and matching W order
        src_aw_valid_i = 3'b110; mst_aw_ready_i = 1'b1;
        cycle(); chk("rr_first_grant", s_aw_sel, 1);
        cycle(); chk("rr_second_grant", s_aw_sel, 2);
        idle();
        src_w_valid_i = 3'b110; src_w_last_i = 3'b110; mst_w_ready_i = 1'b1;
        cycle(); chk("w_order_first", s_w_sel, 1);
        cycle(); chk("w_order_second", s_w_sel, 2);
        idle();
        cycle(); chk("busy_outstanding_b", s_busy, 1);
        mst_b_valid_i = 1'b1; b_src_i = 2'd1; src_b_ready_i = 3'b111;
        cycle(); chk("b_route_src1", s_b_valid, 3'b010);
        b_src_i = 2'd2;
        cycle(); chk("b_route_src2", s_b_valid, 3'b100);
        idle();
        cycle(); chk("idle_after_b", s_busy, 0);

        // Grant lock while AW is stalled
        src_aw_valid_i = 3'b100;
        cycle(); chk("lock_c0", s_aw_sel, 2);
        src_aw_valid_i = 3'b110;
        cycle(); chk("lock_c1", s_aw_sel, 2);
        cycle(); chk("lock_c2", s_aw_sel, 2);
        mst_aw_ready_i = 1'b1;
        cycle(); chk("lock_hs_sel", s_aw_sel, 2); chk("lock_hs_rdy", s_aw_rdy, 3'b100);
        src_aw_valid_i = 3'b010;
        cycle(); chk("after_lock_src1", s_aw_sel, 1);
        do_reset();

        // FIFO full / counter limit
        src_aw_valid_i = 3'b100; mst_aw_ready_i = 1'b1;
        repeat (4) cycle();
        cycle(); chk("full_hold", s_aw_valid, 0);
        src_w_valid_i = 3'b100; src_w_last_i = 3'b100; mst_w_ready_i = 1'b1;
        cycle(); chk("full_hold_pop_cycle", s_aw_valid, 0);
        src_w_valid_i = '0; mst_w_ready_i = 1'b0;
        cycle(); chk("cnt_limit_hold", s_aw_valid, 0);
        mst_b_valid_i = 1'b1; b_src_i = 2'd2; src_b_ready_i = 3'b100;
        cycle(); chk("cnt_limit_b_cycle", s_aw_valid, 0);
        mst_b_valid_i = 1'b0;
        cycle(); chk("cnt_limit_release", s_aw_valid, 1);
        do_reset();

        // Multi-beat burst with toggling W ready
        src_aw_valid_i = 3'b010; mst_aw_ready_i = 1'b1; cycle();
        src_aw_valid_i = 3'b100; cycle();
        idle();
        src_w_valid_i = 3'b110;
        beats = 0; n = 0;
        while (beats < 4 && n < 20) begin
            src_w_last_i  = (beats == 3) ? 3'b110 : 3'b100;
            mst_w_ready_i = (n % 2 == 1);
            cycle();
            if (s_w_hs && s_w_sel == 2'd1) beats++;
            chk("burst_src2_blocked", s_w_rdy[2], 0);
            n++;
        end
        chk("burst_beats", beats, 4);
        mst_w_ready_i = 1'b0;
        cycle(); chk("burst_next_head", s_w_sel, 2);
        do_reset();

        // Unexpected B
        mst_b_valid_i = 1'b1; b_src_i = 2'd1; src_b_ready_i = 3'b000;
        cycle(); chk("ub_sink_ready", s_b_ready, 1); chk("ub_no_valid", s_b_valid, 0);
        chk("ub_err_not_yet", s_err, 0);
        idle();
        cycle(); chk("ub_err_set", s_err, 1);
        repeat (3) begin cycle(); chk("ub_err_sticky", s_err, 1); end
        do_reset(); chk("ub_err_clear", s_err, 0);

        // Reset mid-burst
        src_aw_valid_i = 3'b010; mst_aw_ready_i = 1'b1;
        cycle(); cycle();
        idle();
        src_w_valid_i = 3'b010; mst_w_ready_i = 1'b1;
        cycle();
        rst_i = 1'b1; cycle(); rst_i = 1'b0;
        cycle(); chk("midrst_busy", s_busy, 0); chk("midrst_w_valid", s_w_valid, 0);
        src_aw_valid_i = 3'b111; mst_aw_ready_i = 1'b1;
        cycle(); chk("midrst_rr", s_aw_sel, 0);
        idle();
        mst_b_valid_i = 1'b1; b_src_i = 2'd1; src_b_ready_i = 3'b010;
        cycle(); chk("stale_b_no_valid", s_b_valid, 0);
        idle();
        cycle(); chk("stale_b_err", s_err, 1);
        do_reset();

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            rst_i          = ($urandom_range(0, 199) == 0);
            src_aw_valid_i = N'($urandom);
            mst_aw_ready_i = ($urandom_range(0, 9) < 7);
            src_w_valid_i  = N'($urandom);
            src_w_last_i   = N'($urandom) & N'($urandom);
            mst_w_ready_i  = ($urandom_range(0, 9) < 6);
            mst_b_valid_i  = ($urandom_range(0, 9) < 3);
            b_src_i        = 2'($urandom_range(0, 3));
            src_b_ready_i  = N'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
